// File: rtl/imem_loader_if.sv
// Byte-stream host link plus instruction-memory write port and load status for imem_loader.
// The slave modport is the loader; the master modport is the host / boot controller side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_error;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
    input  core_reset, load_done, load_error
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
    output core_reset, load_done, load_error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses LEN/payload/XOR-checksum frames into 32-bit imem writes and
// holds the core in reset until a verified image is loaded. All outputs are registered.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Length is compared in 17 bits so N = 2^ADDR_W (up to 65536) stays representable.
  localparam logic [16:0] LEN_MAX = 17'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          xor_q, xor_d;
  logic [ADDR_W:0]     widx_q, widx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic [WORD_W-1:0]   asm_nxt;
  logic [ADDR_W:0]     widx_nxt;
  logic [16:0]         len_rx;

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    xor_d    = xor_q;
    widx_d   = widx_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    accept   = bus.byte_valid && ready_q;
    asm_nxt  = {bus.byte_data, asm_q[WORD_W-1:8]};
    widx_nxt = widx_q + 1'b1;
    len_rx   = {1'b0, bus.byte_data, len_lo_q};

    if (accept) begin
      xor_d = xor_q ^ bus.byte_data;
      case (state_q)
        ST_LEN0: begin
          len_lo_d = bus.byte_data;
          state_d  = ST_LEN1;
        end
        ST_LEN1: begin
          len_d = len_rx[15:0];
          if (len_rx > LEN_MAX) begin
            state_d = ST_ERROR;
          end else if (len_rx == 17'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          asm_d  = asm_nxt;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = asm_nxt;
            widx_d  = widx_nxt;
            if (17'(widx_nxt) == {1'b0, len_q}) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          state_d = (bus.byte_data == xor_q) ? ST_DONE : ST_ERROR;
        end
        default: state_d = state_q;
      endcase
    end

    // Status flops follow the next state so they switch on the transition edge.
    ready_d    = (state_d != ST_DONE) && (state_d != ST_ERROR);
    core_rst_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LEN0;
      len_lo_q   <= '0;
      len_q      <= '0;
      xor_q      <= '0;
      widx_q     <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b1;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      widx_q     <= widx_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_reset = core_rst_q;
  assign bus.load_done  = done_q;
  assign bus.load_error = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames go in through the host link, a frame-level model
// predicts writes and final status, and a negedge monitor scores every imem write.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  exp_q[$];
  logic prev_we  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b0 && bus.imem_we === 1'b1) begin
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("write_data", bus.imem_wdata, e.data);
      end
    end
    prev_we = (reset === 1'b0) && (bus.imem_we === 1'b1);
  end

  // Frame-level reference: returns 0 = incomplete, 1 = done, 2 = error, and the index
  // of the byte that terminates the frame. Expected writes go into the scoreboard.
  function automatic int model_frame(input logic [7:0] fr[$], output int term_idx);
    int         n;
    logic [7:0] x;
    wr_t        w;
    term_idx = -1;
    if (fr.size() < 2) return 0;
    n = int'({fr[1], fr[0]});
    if (n > (1 << ADDR_W)) begin
      term_idx = 1;
      return 2;
    end
    for (int i = 0; i < n; i++) begin
      if (fr.size() >= 2 + 4 * i + 4) begin
        w.addr = ADDR_W'(i);
        w.data = {fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]};
        exp_q.push_back(w);
      end
    end
    if (fr.size() <= 2 + 4 * n) return 0;
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ fr[i];
    term_idx = 2 + 4 * n;
    return (fr[2+4*n] == x) ? 1 : 2;
  endfunction

  task automatic build_frame(input int n, input bit bad, output logic [7:0] fr[$]);
    logic [7:0] x;
    fr.delete();
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) fr.push_back(8'($urandom));
    x = 8'h00;
    foreach (fr[i]) x = x ^ fr[i];
    if (bad) x = x ^ 8'(1 + $urandom_range(0, 254));
    fr.push_back(x);
  endtask

  // Called and returns one time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd1);
    check({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    check({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
    check({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
    check({tag, "_core_reset"}, 32'(bus.core_reset), 32'd1);
    check({tag, "_load_done"},  32'(bus.load_done),  32'd0);
    check({tag, "_load_error"}, 32'(bus.load_error), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [7:0] fr[$], input int max_gap);
    int outcome;
    int term;
    outcome = model_frame(fr, term);
    foreach (fr[k]) begin
      send_byte(fr[k], max_gap);
      if (k == term) begin
        check({name, "_done_at_edge"},  32'(bus.load_done),  32'(outcome == 1));
        check({name, "_error_at_edge"}, 32'(bus.load_error), 32'(outcome == 2));
        check({name, "_corerst_at_edge"}, 32'(bus.core_reset), 32'(outcome != 1));
      end
    end
    // Trailing bytes must be ignored once the loader is terminal.
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_final_done"},   32'(bus.load_done),  32'(outcome == 1));
    check({name, "_final_error"},  32'(bus.load_error), 32'(outcome == 2));
    check({name, "_final_corerst"}, 32'(bus.core_reset), 32'(outcome != 1));
    check({name, "_final_ready"},  32'(bus.byte_ready), 32'(outcome == 0));
    check({name, "_writes_left"},  32'(exp_q.size()),   32'd0);
    exp_q.delete();
  endtask

  logic [7:0] nom[$];
  logic [7:0] fr[$];

  initial begin
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    nom = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h01, 8'hFE, 8'h23, 8'h26, 8'h81, 8'h02, 8'h69};
    #2;
    check_reset_vals("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_frame("nominal", nom, 0);

    do_reset();
    fr = nom;
    fr[fr.size()-1] = 8'h68;
    run_frame("bad_csum", fr, 0);

    do_reset();
    fr = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", fr, 0);

    do_reset();
    fr = '{8'h01, 8'h01};
    run_frame("oversize", fr, 0);

    do_reset();
    build_frame(256, 1'b0, fr);
    send_byte(fr[0], 0);
    send_byte(fr[1], 0);
    check("n256_ready", 32'(bus.byte_ready), 32'd1);
    check("n256_error", 32'(bus.load_error), 32'd0);
    do_reset();
    run_frame("n256_full", fr, 0);

    do_reset();
    run_frame("gaps", nom, 5);

    // Reset while the first word's write strobe is on the bus.
    do_reset();
    for (int k = 0; k < 6; k++) send_byte(nom[k], 0);
    check("mid_we_before_reset", 32'(bus.imem_we), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("mid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_frame("reload", nom, 0);

    for (int t = 0; t < 8; t++) begin
      do_reset();
      build_frame(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), fr);
      run_frame("random", fr, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the single-cycle RV32I datapath. It accepts a byte stream from a host link, assembles little-endian 32-bit words and writes them into instruction memory through a write port. It holds the core in reset until a complete, checksum-verified image is present, so programs are loaded without hierarchical writes into `inst_mem`.

## Interface

Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `WORD_W`, default 32: instruction word width. Fixed at 32; other values are unsupported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `byte_valid`  in  1  host byte present.
- `byte_data`  in  8  host byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  word being written.
- `core_reset`  out  1  active-high reset to the datapath.
- `load_done`  out  1  image loaded and verified (sticky).
- `load_error`  out  1  length or checksum failure (sticky).

## Operation

Frame format, in byte order:
- LEN_LO, LEN_HI: 16-bit word count N.
- N×4 payload bytes: each word least-significant byte first.
- CSUM: XOR of every preceding frame byte, including both length bytes.

Handshake: a byte is accepted on a rising edge where `byte_valid && byte_ready`. Bytes presented while `byte_ready` is 0 are ignored and never buffered.

States:
- LEN0: capture LEN_LO, then go to LEN1.
- LEN1: capture LEN_HI.
  - If N > 2^ADDR_W, go to ERROR.
  - Else if N == 0, go to CSUM.
  - Else go to DATA.
- DATA: 2-bit byte counter. Bytes shift into the word assembler LSB-first.
  - On the 4th byte, the assembled word is registered for writing at the current word index. The word index increments and the byte counter wraps to 0.
  - After word N-1 completes, go to CSUM.
- CSUM: compare the received byte with the running XOR.
  - Equal: go to DONE.
  - Unequal: go to ERROR.
- DONE: terminal until `reset`.
- ERROR: terminal until `reset`.

Outputs by state:
- `byte_ready` = 1 in LEN0, LEN1, DATA and CSUM; 0 in DONE and ERROR.
- `core_reset` = 1 in every state except DONE. A failed load never releases the core.
- `load_done` = 1 only in DONE. `load_error` = 1 only in ERROR.

Width rules:
- The running XOR is 8 bits.
- The word index is ADDR_W+1 bits so that N = 2^ADDR_W is representable. `imem_addr` is its low ADDR_W bits.
- Words already written before an ERROR are left in memory and are not erased.

## Timing

Reset values, applied asynchronously:
- State LEN0.
- `byte_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
- `core_reset`=1, `load_done`=0, `load_error`=0.
- XOR, word index and byte counter cleared.

Write timing:
- When the 4th byte of a word is accepted at edge k, `imem_we`=1 for exactly the cycle after edge k, with `imem_addr`/`imem_wdata` valid in that same cycle. Memory captures the word at edge k+1.
- Writes are one-cycle pulses. Back-to-back words at full byte rate produce a strobe every 4 cycles at the earliest.

State-output timing:
- All outputs are registered and change on the same edge as the state transition.
- `load_done` rises and `core_reset` falls on the edge that accepts a matching CSUM byte. That edge is at least edge k+1 after the last payload byte, so the final write always completes before the core leaves reset.
- `load_error` rises on the edge that accepts the failing LEN_HI or CSUM byte.

Boundary and reset behaviour:
- Minimum frame (N=0) reaches DONE 3 accepted bytes after reset.
- `reset` asserted mid-frame, including during an `imem_we` cycle, immediately drops `imem_we` and returns every register to its reset value. The next byte accepted is treated as LEN_LO.

## Test plan

- Nominal load, N=2: stream 02 00 13 01 01 FE 23 26 81 02 69 with `byte_valid` held high. Required:
  - Writes of 0xfe010113 at address 0 and 0x02812623 at address 1.
  - `load_done`=1 and `core_reset`=0 on the edge accepting 0x69.
- Bad checksum: same frame with final byte 0x68. Required:
  - Both writes occur.
  - `load_error`=1 and `core_reset` stays 1.
  - `byte_ready`=0 afterwards; further bytes are ignored.
- Empty image: 00 00 00. Required: no `imem_we` pulse; DONE after the 3rd byte.
- Oversize length, ADDR_W=8: 01 01. Required:
  - ERROR on the edge accepting 0x01 (N=257).
  - No writes.
  - N=256 (00 01) is accepted and proceeds to DATA.
- Backpressure gaps: nominal frame with `byte_valid` low for random 0–5 cycles between bytes. Required: identical writes, addresses and final state as the gap-free run.
- Reset mid-load: assert `reset` after byte 6 of the nominal frame, then resend the full frame. Required:
  - Outputs return to reset values asynchronously.
  - The second frame loads correctly and reaches DONE.
